// File: rtl/clk_div_pkg.sv
// Shared types and constants for the run-time clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_e;

    // Smallest ratio that still gives one high and one low cycle.
    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio-change handshake between config logic (master) and the divider controller (slave).
interface clk_div_ctrl_if #(
    parameter int unsigned DIV_W = 8
);

    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );

endinterface

// File: rtl/clk_div_core.sv
// Period counter and registered out_clk/out_tick generation for a ratio held in div_q.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             wrap,
    output logic             out_clk,
    output logic             out_tick
);

    logic             run_q;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] high_d;

    // run_q mirrors "currently running"; run is "running next cycle".
    assign wrap = run_q && (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        div_d  = load ? load_div : div_q;
        cnt_d  = (run && run_q && !wrap) ? cnt_q + DIV_W'(1) : '0;
        high_d = div_d - (div_d >> 1);
    end

    // Outputs are computed from next-state values so they line up with the visible cnt_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            div_q    <= DIV_W'(DEF_DIV);
            out_clk  <= 1'b0;
            out_tick <= 1'b0;
        end else begin
            run_q    <= run;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            out_clk  <= run && (cnt_d < high_d);
            out_tick <= run && (cnt_d == '0);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Start/stop FSM and pending-ratio handshake; ratio changes land only on period boundaries.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    clk_div_ctrl_if.slave        cfg,
    output logic                 out_clk,
    output logic                 out_tick,
    output logic                 busy
);

    state_e           state_q, state_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             err_q, err_d;
    logic             accept;
    logic             load;
    logic             wrap;
    logic             run;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = StStop;
            StStop: begin
                if (en) begin
                    state_d = StRun;
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign run = (state_d != StIdle);

    // load and accept are exclusive: one needs pend_q set, the other clear.
    always_comb begin
        accept     = cfg.cfg_valid && !pend_q;
        load       = pend_q && (wrap || state_q == StIdle);
        err_d      = accept && (cfg.cfg_div < DIV_W'(DIV_MIN));
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        if (load) begin
            pend_d = 1'b0;
        end else if (accept && !err_d) begin
            pend_d     = 1'b1;
            pend_div_d = cfg.cfg_div;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            pend_q     <= 1'b0;
            pend_div_q <= DIV_W'(DEF_DIV);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            err_q      <= err_d;
        end
    end

    clk_div_core #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .load     (load),
        .load_div (pend_div_q),
        .wrap     (wrap),
        .out_clk  (out_clk),
        .out_tick (out_tick)
    );

    assign cfg.cfg_ready = !pend_q;
    assign cfg.cfg_err   = err_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: start/stop, ratio handshake, async reset, wrap-cycle accept.
module tb_clk_div_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic out_clk, out_tick, busy;
    int   n_cmp  = 0;
    int   n_fail = 0;

    clk_div_ctrl_if #(.DIV_W(8)) cfg_if ();

    clk_div_ctrl #(
        .DIV_W   (8),
        .DEF_DIV (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg      (cfg_if.slave),
        .out_clk  (out_clk),
        .out_tick (out_tick),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Waits for a tick, then counts one full period; ends on the next tick sample.
    task automatic measure(output int per, output int hi);
        int w = 0;
        per = -1;
        hi  = 0;
        while (out_tick !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (out_tick !== 1'b1) return;
        per = 0;
        do begin
            if (out_clk === 1'b1) hi++;
            per++;
            @(negedge clk);
        end while (out_tick !== 1'b1 && per < 40);
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_clk !== 1'b0) begin n_fail++; $display("FAIL reset_out_clk got %b want 0", out_clk); end
        n_cmp++; if (out_tick !== 1'b0) begin n_fail++; $display("FAIL reset_out_tick got %b want 0", out_tick); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_if.cfg_ready); end
        n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b want 0", cfg_if.cfg_err); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_run_default();
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic e = (i % 2 == 0);
            @(negedge clk);
            n_cmp++; if (out_clk !== e) begin n_fail++; $display("FAIL run2_out_clk[%0d] got %b want %b", i, out_clk, e); end
            n_cmp++; if (out_tick !== e) begin n_fail++; $display("FAIL run2_out_tick[%0d] got %b want %b", i, out_tick, e); end
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run2_busy[%0d] got %b want 1", i, busy); end
        end
    endtask

    task automatic test_ratio_change();
        bit e_clk[6]  = '{1, 1, 1, 0, 0, 1};
        bit e_tick[6] = '{1, 0, 0, 0, 0, 1};
        int w = 0;
        while (out_tick !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd5;
        @(negedge clk);
        n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL chg_ready_pending got %b want 0", cfg_if.cfg_ready); end
        n_cmp++; if (out_clk !== 1'b0) begin n_fail++; $display("FAIL chg_old_low got %b want 0", out_clk); end
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (out_clk !== e_clk[i]) begin n_fail++; $display("FAIL chg_out_clk[%0d] got %b want %b", i, out_clk, e_clk[i]); end
            n_cmp++; if (out_tick !== e_tick[i]) begin n_fail++; $display("FAIL chg_out_tick[%0d] got %b want %b", i, out_tick, e_tick[i]); end
            n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL chg_ready[%0d] got %b want 1", i, cfg_if.cfg_ready); end
        end
    endtask

    task automatic test_bad_ratio();
        int per, hi;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd1;
        @(negedge clk);
        n_cmp++; if (cfg_if.cfg_err !== 1'b1) begin n_fail++; $display("FAIL bad_err_pulse got %b want 1", cfg_if.cfg_err); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready got %b want 1", cfg_if.cfg_ready); end
        cfg_if.cfg_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (cfg_if.cfg_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_clear got %b want 0", cfg_if.cfg_err); end
        measure(per, hi);
        n_cmp++; if (per !== 5) begin n_fail++; $display("FAIL bad_period got %0d want 5", per); end
        n_cmp++; if (hi !== 3) begin n_fail++; $display("FAIL bad_high got %0d want 3", hi); end
    endtask

    task automatic test_stop_restart();
        int per, hi;
        bit e_busy[4] = '{1, 1, 0, 0};
        bit e_clk[4]  = '{0, 1, 1, 0};
        bit e_tick[4] = '{0, 1, 0, 0};
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd4;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        measure(per, hi);
        n_cmp++; if (per !== 4) begin n_fail++; $display("FAIL n4_period got %0d want 4", per); end
        n_cmp++; if (hi !== 2) begin n_fail++; $display("FAIL n4_high got %0d want 2", hi); end
        @(negedge clk);
        n_cmp++; if (out_clk !== 1'b1) begin n_fail++; $display("FAIL stop_cnt1_high got %b want 1", out_clk); end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (out_clk !== 1'b0) begin n_fail++; $display("FAIL stop_out_clk[%0d] got %b want 0", i, out_clk); end
            n_cmp++; if (busy !== e_busy[i]) begin n_fail++; $display("FAIL stop_busy[%0d] got %b want %b", i, busy, e_busy[i]); end
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_tick !== 1'b1 || out_clk !== 1'b1) begin n_fail++; $display("FAIL restart got clk=%b tick=%b want 1/1", out_clk, out_tick); end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || out_clk !== 1'b0) begin n_fail++; $display("FAIL reen_cnt2 got busy=%b clk=%b want 1/0", busy, out_clk); end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (out_clk !== e_clk[i]) begin n_fail++; $display("FAIL reen_out_clk[%0d] got %b want %b", i, out_clk, e_clk[i]); end
            n_cmp++; if (out_tick !== e_tick[i]) begin n_fail++; $display("FAIL reen_out_tick[%0d] got %b want %b", i, out_tick, e_tick[i]); end
        end
    endtask

    task automatic test_async_reset();
        int per, hi;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd6;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        measure(per, hi);
        n_cmp++; if (per !== 6) begin n_fail++; $display("FAIL n6_period got %0d want 6", per); end
        n_cmp++; if (hi !== 3) begin n_fail++; $display("FAIL n6_high got %0d want 3", hi); end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd3;
        @(negedge clk);
        n_cmp++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pend_ready got %b want 0", cfg_if.cfg_ready); end
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b0;
        en  = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_clk !== 1'b0 || out_tick !== 1'b0) begin n_fail++; $display("FAIL rst_outs got clk=%b tick=%b want 0/0", out_clk, out_tick); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", cfg_if.cfg_ready); end
        rst = 1'b1;
        en  = 1'b1;
        measure(per, hi);
        n_cmp++; if (per !== 2) begin n_fail++; $display("FAIL rst_def_period got %0d want 2", per); end
        n_cmp++; if (hi !== 1) begin n_fail++; $display("FAIL rst_def_high got %0d want 1", hi); end
    endtask

    task automatic test_wrap_accept();
        bit e_clk[6]   = '{1, 0, 1, 1, 0, 1};
        bit e_tick[6]  = '{1, 0, 1, 0, 0, 1};
        bit e_ready[6] = '{0, 0, 1, 1, 1, 1};
        @(negedge clk);
        n_cmp++; if (out_clk !== 1'b0 || out_tick !== 1'b0) begin n_fail++; $display("FAIL wrap_align got clk=%b tick=%b want 0/0", out_clk, out_tick); end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = 8'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cfg_if.cfg_valid = 1'b0;
            n_cmp++; if (out_clk !== e_clk[i]) begin n_fail++; $display("FAIL wrap_out_clk[%0d] got %b want %b", i, out_clk, e_clk[i]); end
            n_cmp++; if (out_tick !== e_tick[i]) begin n_fail++; $display("FAIL wrap_out_tick[%0d] got %b want %b", i, out_tick, e_tick[i]); end
            n_cmp++; if (cfg_if.cfg_ready !== e_ready[i]) begin n_fail++; $display("FAIL wrap_ready[%0d] got %b want %b", i, cfg_if.cfg_ready, e_ready[i]); end
        end
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = 8'd0;
        test_reset();
        test_run_default();
        test_ratio_change();
        test_bad_ratio();
        test_stop_restart();
        test_async_reset();
        test_wrap_accept();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
